// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the sram-like bus arbiter.
package sram_arb_pkg;

    localparam int SRAM_SIZE_W = 2;

    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sram_arb_picker.sv
// Combinational winner select between the inst and data requesters.
// SRAM_ARB_RR_EN selects round-robin tie-break; otherwise data wins ties.
module sram_arb_picker
    import sram_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
`ifdef SRAM_ARB_RR_EN
    input  logic rr_last,
`endif
    output logic pick_data
);

    always_comb begin
        pick_data = GNT_INST;
        if (d_req && !i_req) begin
            pick_data = GNT_DATA;
        end else if (d_req && i_req) begin
`ifdef SRAM_ARB_RR_EN
            // The requester that was not served last takes the tie.
            pick_data = (rr_last == GNT_INST) ? GNT_DATA : GNT_INST;
`else
            pick_data = GNT_DATA;
`endif
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Serialises inst/data cache sram-like requests onto one master channel.
// Define SRAM_ARB_RR_EN for round-robin tie-break instead of fixed data priority.
module sram_bus_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   i_req,
    input  logic                   i_wr,
    input  logic [SRAM_SIZE_W-1:0] i_size,
    input  logic [ADDR_W-1:0]      i_addr,
    input  logic [DATA_W-1:0]      i_wdata,
    output logic [DATA_W-1:0]      i_rdata,
    output logic                   i_addr_ok,
    output logic                   i_data_ok,

    input  logic                   d_req,
    input  logic                   d_wr,
    input  logic [SRAM_SIZE_W-1:0] d_size,
    input  logic [ADDR_W-1:0]      d_addr,
    input  logic [DATA_W-1:0]      d_wdata,
    output logic [DATA_W-1:0]      d_rdata,
    output logic                   d_addr_ok,
    output logic                   d_data_ok,

    output logic                   m_req,
    output logic                   m_wr,
    output logic [SRAM_SIZE_W-1:0] m_size,
    output logic [ADDR_W-1:0]      m_addr,
    output logic [DATA_W-1:0]      m_wdata,
    input  logic [DATA_W-1:0]      m_rdata,
    input  logic                   m_addr_ok,
    input  logic                   m_data_ok,

    output logic                   busy,
    output logic                   gnt_data
);

    arb_state_t state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       pick_data;
    logic       gnt_req;

`ifdef SRAM_ARB_RR_EN
    logic       rr_q, rr_d;
`endif

    sram_arb_picker u_picker (
        .i_req     (i_req),
        .d_req     (d_req),
`ifdef SRAM_ARB_RR_EN
        .rr_last   (rr_q),
`endif
        .pick_data (pick_data)
    );

    assign gnt_req = (gnt_q == GNT_DATA) ? d_req : i_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= GNT_INST;
`ifdef SRAM_ARB_RR_EN
            rr_q    <= GNT_INST;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
`ifdef SRAM_ARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
`ifdef SRAM_ARB_RR_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d = ADDR;
                    gnt_d   = pick_data;
                end
            end
            ADDR: begin
                // A withdrawn request abandons the grant; no handshake has happened yet.
                if (m_addr_ok) begin
                    state_d = DATA;
                end else if (!gnt_req) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (m_data_ok) begin
                    state_d = IDLE;
`ifdef SRAM_ARB_RR_EN
                    rr_d    = gnt_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_req     = 1'b0;
        m_wr      = 1'b0;
        m_size    = '0;
        m_addr    = '0;
        m_wdata   = '0;
        i_addr_ok = 1'b0;
        i_data_ok = 1'b0;
        d_addr_ok = 1'b0;
        d_data_ok = 1'b0;
        case (state_q)
            ADDR: begin
                m_req = 1'b1;
                if (gnt_q == GNT_DATA) begin
                    m_wr      = d_wr;
                    m_size    = d_size;
                    m_addr    = d_addr;
                    m_wdata   = d_wdata;
                    d_addr_ok = m_addr_ok;
                end else begin
                    m_wr      = i_wr;
                    m_size    = i_size;
                    m_addr    = i_addr;
                    m_wdata   = i_wdata;
                    i_addr_ok = m_addr_ok;
                end
            end
            DATA: begin
                if (gnt_q == GNT_DATA) begin
                    d_data_ok = m_data_ok;
                end else begin
                    i_data_ok = m_data_ok;
                end
            end
            default: ;
        endcase
    end

    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;
    assign busy     = (state_q != IDLE);
    assign gnt_data = gnt_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_sram_bus_arbiter;

    localparam logic [31:0] IA = 32'hBFC0_0000;
    localparam logic [31:0] DA = 32'h8000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_addr_ok, m_data_ok;
    logic        busy, gnt_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .busy(busy), .gnt_data(gnt_data)
    );

    typedef struct {
        logic        rst, ir, dr, aok, dok;
        logic [31:0] rd;
        logic        mreq, busy, gnt, iaok, idok, daok, ddok;
        logic [31:0] maddr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, ir, dr, aok, dok, input logic [31:0] rd,
                               input logic mreq, bsy, gnt, iaok, idok, daok, ddok,
                               input logic [31:0] maddr);
        vec_t x;
        x.rst = r; x.ir = ir; x.dr = dr; x.aok = aok; x.dok = dok; x.rd = rd;
        x.mreq = mreq; x.busy = bsy; x.gnt = gnt; x.iaok = iaok; x.idok = idok;
        x.daok = daok; x.ddok = ddok; x.maddr = maddr;
        return x;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=0x%08h expected=0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic serve(input int k, input logic exp_gnt);
        int n = 0;
        while (!m_req && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rr_grant_timeout", k, 32'(n < 10), 32'd1);
        chk("rr_gnt_data", k, 32'(gnt_data), 32'(exp_gnt));
        chk("rr_m_addr", k, m_addr, exp_gnt ? DA : IA);
        m_addr_ok = 1'b1; #1;
        chk("rr_addr_ok", k, {30'd0, i_addr_ok, d_addr_ok}, exp_gnt ? 32'd1 : 32'd2);
        @(negedge clk);
        m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'hA5A5_0000 + 32'(k); #1;
        chk("rr_data_ok", k, {30'd0, i_data_ok, d_data_ok}, exp_gnt ? 32'd1 : 32'd2);
        @(negedge clk);
        m_data_ok = 1'b0; #1;
    endtask

    initial begin
        rst = 1'b1;
        i_req = 0; i_wr = 0; i_size = 2'd2; i_addr = IA; i_wdata = 32'h0;
        d_req = 0; d_wr = 0; d_size = 2'd2; d_addr = DA; d_wdata = 32'h0;
        m_rdata = 0; m_addr_ok = 0; m_data_ok = 0;

        // inst-only read
        tbl.push_back(v(0,1,0,0,0,0,            0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,0,1,0,0,            1,1,0,1,0,0,0,IA));
        tbl.push_back(v(0,0,0,0,0,0,            0,1,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,1,32'h3C1D8000, 0,1,0,0,1,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,            0,0,0,0,0,0,0,0));
        // tie: data first, inst two cycles after data_ok
        tbl.push_back(v(0,1,1,0,0,0,            0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,1,1,0,0,            1,1,1,0,0,1,0,DA));
        tbl.push_back(v(0,1,0,0,0,0,            0,1,1,0,0,0,0,0));
        tbl.push_back(v(0,1,0,0,1,32'h11112222, 0,1,1,0,0,0,1,0));
        tbl.push_back(v(0,1,0,0,0,0,            0,0,1,0,0,0,0,0));
        tbl.push_back(v(0,1,0,0,0,0,            1,1,0,0,0,0,0,IA));
        tbl.push_back(v(0,1,0,1,0,0,            1,1,0,1,0,0,0,IA));
        tbl.push_back(v(0,0,0,0,1,32'h55556666, 0,1,0,0,1,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,            0,0,0,0,0,0,0,0));
        // reset in DATA; late data_ok and stray addr_ok in IDLE are ignored
        tbl.push_back(v(0,0,1,0,0,0,            0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,1,0,0,            1,1,1,0,0,1,0,DA));
        tbl.push_back(v(1,0,0,0,0,0,            0,1,1,0,0,0,0,0));
        tbl.push_back(v(0,0,0,1,1,32'h77778888, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,            0,0,0,0,0,0,0,0));
        // inst withdraws in ADDR, pending data granted after the IDLE cycle
        tbl.push_back(v(0,1,0,0,0,0,            0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,1,0,1,0,            1,1,0,0,0,0,0,IA));
        tbl.push_back(v(0,0,1,0,0,0,            1,1,0,0,0,0,0,IA));
        tbl.push_back(v(0,0,1,0,0,0,            0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,1,0,0,            1,1,1,0,0,1,0,DA));
        tbl.push_back(v(0,0,0,0,1,32'h00000009, 0,1,1,0,0,0,1,0));
        tbl.push_back(v(0,0,0,0,0,0,            0,0,1,0,0,0,0,0));

        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_busy", 0, 32'(busy), 0);
        chk("reset_m_req", 0, 32'(m_req), 0);
        chk("reset_gnt_data", 0, 32'(gnt_data), 0);
        chk("reset_oks", 0, {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 0);
        chk("reset_m_addr", 0, m_addr, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; i_req = tbl[i].ir; d_req = tbl[i].dr;
            m_addr_ok = tbl[i].aok; m_data_ok = tbl[i].dok; m_rdata = tbl[i].rd;
            #1;
            chk("m_req", i, 32'(m_req), 32'(tbl[i].mreq));
            chk("busy", i, 32'(busy), 32'(tbl[i].busy));
            chk("gnt_data", i, 32'(gnt_data), 32'(tbl[i].gnt));
            chk("i_addr_ok", i, 32'(i_addr_ok), 32'(tbl[i].iaok));
            chk("i_data_ok", i, 32'(i_data_ok), 32'(tbl[i].idok));
            chk("d_addr_ok", i, 32'(d_addr_ok), 32'(tbl[i].daok));
            chk("d_data_ok", i, 32'(d_data_ok), 32'(tbl[i].ddok));
            chk("m_addr", i, m_addr, tbl[i].maddr);
            chk("i_rdata", i, i_rdata, tbl[i].rd);
            chk("d_rdata", i, d_rdata, tbl[i].rd);
        end

        // Repeated ties with both requesters held; pointer starts fresh from reset.
        @(negedge clk);
        rst = 1'b1; m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
        @(negedge clk);
        rst = 1'b0; i_req = 1'b1; d_req = 1'b1; #1;
        for (int k = 0; k < 4; k++) begin
`ifdef SRAM_ARB_RR_EN
            serve(k, (k % 2 == 0) ? 1'b1 : 1'b0);
`else
            serve(k, 1'b1);
`endif
        end
        i_req = 1'b0; d_req = 1'b0;

        // Data write with addr_ok on the fourth ADDR cycle.
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b1; d_size = 2'd2; d_wdata = 32'hDEADBEEF; #1;
        chk("wr_idle_m_req", 0, 32'(m_req), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            m_addr_ok = (k == 3); #1;
            chk("wr_m_req", k, 32'(m_req), 1);
            chk("wr_m_wr", k, 32'(m_wr), 1);
            chk("wr_m_size", k, 32'(m_size), 2);
            chk("wr_m_wdata", k, m_wdata, 32'hDEADBEEF);
            chk("wr_d_addr_ok", k, 32'(d_addr_ok), (k == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        m_addr_ok = 1'b0; d_req = 1'b0; #1;
        chk("wr_m_req_drop", 0, 32'(m_req), 0);
        chk("wr_busy_data", 0, 32'(busy), 1);
        chk("wr_m_wdata_zero", 0, m_wdata, 0);
        m_data_ok = 1'b1; #1;
        chk("wr_d_data_ok", 0, 32'(d_data_ok), 1);
        chk("wr_i_data_ok", 0, 32'(i_data_ok), 0);
        @(negedge clk);
        m_data_ok = 1'b0; d_wr = 1'b0; d_wdata = 32'h0; #1;
        chk("wr_done_busy", 0, 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Shares one sram-like master channel between the instruction-cache and data-cache miss/refill ports. Sits between the cache wrapper's `cache_inst_*` / `cache_data_*` outputs and the single sram-to-AXI bridge. Serialises transactions: exactly one in flight, held from grant until `data_ok`. Fixed data-priority arbitration by default; round-robin when configured.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_req`, `i_wr`, `i_size[1:0]`, `i_addr[ADDR_W]`, `i_wdata[DATA_W]`  in: inst requester, sram-like; fields held stable while `i_req` is high.
- `i_rdata`  out  DATA_W; `i_addr_ok`, `i_data_ok`  out  1: inst responses.
- `d_req`, `d_wr`, `d_size`, `d_addr`, `d_wdata`  in; `d_rdata`, `d_addr_ok`, `d_data_ok`  out: data requester, same shapes.
- `m_req`, `m_wr`  out  1; `m_size`  out  2; `m_addr`  out  ADDR_W; `m_wdata`  out  DATA_W: master channel.
- `m_rdata`  in  DATA_W; `m_addr_ok`, `m_data_ok`  in  1: master responses.
- `busy`  out  1: a transaction is granted and not yet complete.
- `gnt_data`  out  1: current/last grant owner, 1 = data, 0 = inst.

## Operation
- States: IDLE, ADDR, DATA. `gnt_data` is a register, updated only on IDLE->ADDR.
- IDLE: `m_req`=0. If any of `i_req`/`d_req` is high, latch the winner into `gnt_data` and go to ADDR. Winner: only requester, or on a tie, data (fixed) or per round-robin (see Configuration).
- ADDR: `m_req`=1; `m_wr`/`m_size`/`m_addr`/`m_wdata` pass through combinationally from the granted requester. Granted `*_addr_ok` = `m_addr_ok`. On `m_addr_ok` go to DATA. If the granted requester drops `req` without `m_addr_ok`, go to IDLE (no handshake has occurred).
- DATA: `m_req`=0. Granted `*_data_ok` = `m_data_ok`. On `m_data_ok` go to IDLE.
- `i_rdata` and `d_rdata` both carry `m_rdata` unconditionally; consumers qualify with `data_ok`.
- Non-granted requester: `addr_ok`=0, `data_ok`=0 at all times.
- `m_data_ok` in IDLE or ADDR is ignored. `m_addr_ok` outside ADDR is ignored.
- `m_wr`/`m_size`/`m_addr`/`m_wdata` are 0 outside ADDR.
- `busy` = (state != IDLE).

## Timing
- Reset: state IDLE, `gnt_data`=0, RR pointer = inst-last (data next); all outputs 0.
- Reset mid-transaction returns to IDLE next edge. The master side is reset by the same `rst`.
- Arbitration bubble: a request seen in IDLE at cycle n gives `m_req`=1 at cycle n+1.
- Zero-cycle pass-through of `addr_ok` and `data_ok`: both are visible in the same cycle they arrive from the master.
- Back-to-back: `data_ok` at cycle n gives IDLE at n+1 and `m_req` for the next grant at n+2. Minimum 3 cycles per transaction.
- `m_addr_ok` in the first ADDR cycle is legal.

## Configuration
- `SRAM_ARB_RR_EN` defined: 1-bit last-served pointer, updated on each DATA->IDLE. On a tie, the requester not served last wins.
- `SRAM_ARB_RR_EN` undefined: data always wins ties. No pointer register exists.
- Non-tie behaviour is identical in both builds.

## Structure
- Package `sram_arb_pkg`:
  - `arb_state_t` enum (IDLE, ADDR, DATA).
  - constants `GNT_INST`=1'b0, `GNT_DATA`=1'b1.
  - `SRAM_SIZE_W`=2.
- Sub-module `sram_arb_picker`: combinational winner select from `i_req`, `d_req` and the RR pointer; holds the `SRAM_ARB_RR_EN` conditional. The FSM and muxes stay in the top.

## Test plan
- Inst-only read, `i_addr`=0xBFC00000, master `addr_ok` at +1 and `data_ok` with `m_rdata`=0x3C1D8000 at +3 -> `i_addr_ok` and `i_data_ok` each pulse once, `i_rdata`=0x3C1D8000, `d_*_ok` stay 0.
- Simultaneous `i_req`/`d_req` from IDLE, fixed build -> data served first, `m_addr`=`d_addr`; inst served second, starting 2 cycles after data's `data_ok`.
- Same tie twice in succession with `SRAM_ARB_RR_EN` -> grant order data, inst, data, inst.
- Data write `d_wr`=1, `d_size`=2, `d_wdata`=0xDEADBEEF, `addr_ok` delayed 4 cycles -> `m_wdata`/`m_size`/`m_wr` stable for all 4 ADDR cycles, `m_req` drops the cycle after `addr_ok`.
- `rst` asserted in DATA -> next cycle `busy`=0, `m_req`=0; a late `m_data_ok` after reset produces no `*_data_ok`.
- Granted `i_req` withdrawn in ADDR before `addr_ok` -> IDLE next cycle; pending `d_req` granted the cycle after.
